// File: rtl/i2c_oled_rx.sv
// I2C write-only slave receiver for the SSD1306 link: address, control byte and data/command bytes.
// Optional glitch filter on the synchronized lines: define I2C_OLED_RX_GLITCH_FILTER_EN.
module i2c_oled_rx #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h3C,
  parameter int         SYNC_STAGES = 2,
  parameter int         FILT_LEN    = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       busy,
  output logic       addr_match,
  output logic       rx_valid,
  output logic       rx_dcn,
  output logic [7:0] rx_data,
  output logic       err
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ADDR     = 3'd1;
  localparam logic [2:0] S_ADDR_ACK = 3'd2;
  localparam logic [2:0] S_CTRL     = 3'd3;
  localparam logic [2:0] S_CTRL_ACK = 3'd4;
  localparam logic [2:0] S_DATA     = 3'd5;
  localparam logic [2:0] S_DATA_ACK = 3'd6;
  localparam logic [2:0] S_IGNORE   = 3'd7;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic scl_s, sda_s, scl_d, sda_d;
  logic scl_rise, scl_fall, start_det, stop_det;

  logic [2:0] state;
  logic [3:0] bit_cnt, cnt_inc;
  logic [7:0] shift, next_shift;
  logic       ack_phase, co, dc, byte_done, in_byte;

  // Synchronizers reset to 1 so an idle (pulled-up) bus produces no edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
    end
  end

`ifdef I2C_OLED_RX_GLITCH_FILTER_EN
  localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FILT_LEN - 1);

  logic          scl_filt, sda_filt;
  logic [CW-1:0] scl_cnt, sda_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_filt <= 1'b1;
      sda_filt <= 1'b1;
      scl_cnt  <= '0;
      sda_cnt  <= '0;
    end else begin
      if (scl_sync[SYNC_STAGES-1] == scl_filt) begin
        scl_cnt <= '0;
      end else if (scl_cnt == CNT_LAST) begin
        scl_filt <= scl_sync[SYNC_STAGES-1];
        scl_cnt  <= '0;
      end else begin
        scl_cnt <= scl_cnt + 1'b1;
      end
      if (sda_sync[SYNC_STAGES-1] == sda_filt) begin
        sda_cnt <= '0;
      end else if (sda_cnt == CNT_LAST) begin
        sda_filt <= sda_sync[SYNC_STAGES-1];
        sda_cnt  <= '0;
      end else begin
        sda_cnt <= sda_cnt + 1'b1;
      end
    end
  end

  assign scl_s = scl_filt;
  assign sda_s = sda_filt;
`else
  logic filt_unused;
  assign filt_unused = (FILT_LEN != 0);
  assign scl_s = scl_sync[SYNC_STAGES-1];
  assign sda_s = sda_sync[SYNC_STAGES-1];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_d <= 1'b1;
      sda_d <= 1'b1;
    end else begin
      scl_d <= scl_s;
      sda_d <= sda_s;
    end
  end

  assign scl_rise   = scl_s & ~scl_d;
  assign scl_fall   = ~scl_s & scl_d;
  assign start_det  = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det   = scl_s & scl_d & ~sda_d & sda_s;
  assign cnt_inc    = (bit_cnt == 4'hF) ? bit_cnt : bit_cnt + 4'd1;
  assign next_shift = {shift[6:0], sda_s};
  assign in_byte    = (state == S_ADDR) || (state == S_CTRL) || (state == S_DATA);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      bit_cnt    <= 4'd0;
      shift      <= 8'h00;
      ack_phase  <= 1'b0;
      co         <= 1'b0;
      dc         <= 1'b0;
      byte_done  <= 1'b0;
      sda_oe     <= 1'b0;
      busy       <= 1'b0;
      addr_match <= 1'b0;
      rx_valid   <= 1'b0;
      rx_dcn     <= 1'b0;
      rx_data    <= 8'h00;
      err        <= 1'b0;
    end else begin
      rx_valid  <= byte_done;
      byte_done <= 1'b0;
      if (byte_done) begin
        rx_data <= shift;
        rx_dcn  <= dc;
      end

      if (start_det) begin
        state      <= S_ADDR;
        bit_cnt    <= 4'd0;
        ack_phase  <= 1'b0;
        busy       <= 1'b1;
        err        <= 1'b0;
        sda_oe     <= 1'b0;
        addr_match <= 1'b0;
      end else if (stop_det) begin
        state      <= S_IDLE;
        ack_phase  <= 1'b0;
        busy       <= 1'b0;
        addr_match <= 1'b0;
        sda_oe     <= 1'b0;
        // The SCL rise that precedes a STOP is always counted as one bit, so a
        // byte is only truly partial once two or more bits have been sampled.
        if (in_byte && bit_cnt > 4'd1) err <= 1'b1;
      end else begin
        case (state)
          S_ADDR: begin
            if (scl_rise) begin
              shift   <= next_shift;
              bit_cnt <= cnt_inc;
              if (bit_cnt == 4'd7) begin
                if (next_shift[7:1] == SLAVE_ADDR && !next_shift[0]) begin
                  state <= S_ADDR_ACK;
                end else begin
                  state <= S_IGNORE;
                  if (next_shift[7:1] == SLAVE_ADDR) err <= 1'b1;
                end
              end
            end
          end
          S_CTRL: begin
            if (scl_rise) begin
              shift   <= next_shift;
              bit_cnt <= cnt_inc;
              if (bit_cnt == 4'd7) begin
                co    <= next_shift[7];
                dc    <= next_shift[6];
                if (next_shift[5:0] != 6'd0) err <= 1'b1;
                state <= S_CTRL_ACK;
              end
            end
          end
          S_DATA: begin
            if (scl_rise) begin
              shift   <= next_shift;
              bit_cnt <= cnt_inc;
              if (bit_cnt == 4'd7) begin
                byte_done <= 1'b1;
                state     <= S_DATA_ACK;
              end
            end
          end
          // First SCL fall drives the ACK, the second releases it and moves on.
          S_ADDR_ACK, S_CTRL_ACK, S_DATA_ACK: begin
            if (scl_fall) begin
              if (!ack_phase) begin
                sda_oe    <= 1'b1;
                ack_phase <= 1'b1;
              end else begin
                sda_oe    <= 1'b0;
                ack_phase <= 1'b0;
                bit_cnt   <= 4'd0;
                if (state == S_ADDR_ACK) begin
                  addr_match <= 1'b1;
                  state      <= S_CTRL;
                end else if (state == S_CTRL_ACK) begin
                  state <= S_DATA;
                end else begin
                  state <= co ? S_CTRL : S_DATA;
                end
              end
            end
          end
          S_IGNORE: sda_oe <= 1'b0;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_oled_rx.sv
// Self-checking bench for i2c_oled_rx: table-driven transfers plus hand sequences, with a
// scoreboard of expected bytes; honors I2C_OLED_RX_GLITCH_FILTER_EN for the glitch case.
`timescale 1ns/1ps
module tb_i2c_oled_rx;

  localparam int PH   = 50;
  localparam int HALF = 25;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       sda_drv = 1'b1;
  logic       sda_line;
  logic       sda_oe, busy, addr_match, rx_valid, rx_dcn, err;
  logic [7:0] rx_data;

  assign sda_line = sda_drv & ~sda_oe;

  always #5 clk = ~clk;

  i2c_oled_rx #(.SLAVE_ADDR(7'h3C), .SYNC_STAGES(2), .FILT_LEN(3)) dut (
    .clk(clk), .rst_n(rst_n), .scl(scl), .sda_in(sda_line), .sda_oe(sda_oe),
    .busy(busy), .addr_match(addr_match), .rx_valid(rx_valid), .rx_dcn(rx_dcn),
    .rx_data(rx_data), .err(err)
  );

  typedef struct {
    logic [7:0]  addr;
    logic [7:0]  ctrl;
    int          nbytes;
    logic [23:0] data;
    logic        addr_ack;
    logic        match;
    int          acks;
    logic        dcn;
    logic        err;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic       dcn;
  } exp_t;

  vec_t vecs[6];
  exp_t exp_q[$];

  // Monitor: logs every rx_valid pulse and counts ACK assertions.
  logic [8:0] rx_log [0:255];
  int   rx_cnt = 0;
  int   ack_cnt = 0;
  int   wide_cnt = 0;
  logic prev_oe = 1'b0;
  logic prev_valid = 1'b0;

  always @(negedge clk) begin
    prev_oe    <= sda_oe;
    prev_valid <= rx_valid;
    if (sda_oe && !prev_oe) ack_cnt <= ack_cnt + 1;
    if (rx_valid) begin
      rx_log[rx_cnt[7:0]] <= {rx_dcn, rx_data};
      rx_cnt <= rx_cnt + 1;
    end
    if (rx_valid && prev_valid) wide_cnt <= wide_cnt + 1;
  end

  int n_checks = 0;
  int n_errors = 0;
  int rd_ptr = 0;
  int base_ack = 0;

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drainScoreboard(input string name);
    logic [8:0] got;
    exp_t       e;
    while (rd_ptr < rx_cnt) begin
      got = rx_log[rd_ptr[7:0]];
      rd_ptr++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("[TB] FAIL %s_unexpected_rx: got %0h, expected no byte", name, got[7:0]);
      end else begin
        e = exp_q.pop_front();
        checkOutput({name, "_rx_data"}, {24'd0, got[7:0]}, {24'd0, e.data});
        checkOutput({name, "_rx_dcn"}, {31'd0, got[8]}, {31'd0, e.dcn});
      end
    end
    checkOutput({name, "_missing_rx"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic i2c_start();
    sda_drv = 1'b1; wait_clks(HALF);
    scl = 1'b1;     wait_clks(HALF);
    sda_drv = 1'b0; wait_clks(HALF);
    scl = 1'b0;     wait_clks(HALF);
  endtask

  task automatic i2c_stop();
    sda_drv = 1'b0; wait_clks(HALF);
    scl = 1'b1;     wait_clks(HALF);
    sda_drv = 1'b1; wait_clks(PH);
  endtask

  // A glitch is a 2-clk low pulse in the middle of the SCL high phase.
  task automatic send_bit(input logic b, input logic glitch);
    sda_drv = b; wait_clks(HALF);
    scl = 1'b1;
    if (glitch) begin
      wait_clks(PH / 2);
      scl = 1'b0; wait_clks(2);
      scl = 1'b1; wait_clks(PH / 2 - 2);
    end else begin
      wait_clks(PH);
    end
    scl = 1'b0; wait_clks(HALF);
  endtask

  task automatic recv_ack(output logic ack);
    sda_drv = 1'b1; wait_clks(HALF);
    scl = 1'b1;     wait_clks(PH / 2);
    ack = ~sda_line; wait_clks(PH / 2);
    scl = 1'b0;     wait_clks(HALF);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic glitch_first, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(d[i], glitch_first && (i == 7));
    recv_ack(ack);
  endtask

  task automatic applyStimulus(input vec_t v);
    logic       ack;
    logic [7:0] b;
    base_ack = ack_cnt;
    i2c_start();
    checkOutput("busy_after_start", {31'd0, busy}, 1);
    checkOutput("err_clear_on_start", {31'd0, err}, 0);
    send_byte(v.addr, 1'b0, ack);
    checkOutput("addr_ack", {31'd0, ack}, {31'd0, v.addr_ack});
    send_byte(v.ctrl, 1'b0, ack);
    for (int i = 0; i < v.nbytes; i++) begin
      b = v.data[23 - 8 * i -: 8];
      if (v.addr_ack) exp_q.push_back('{data: b, dcn: v.dcn});
      send_byte(b, 1'b0, ack);
    end
    checkOutput("addr_match_in_xfer", {31'd0, addr_match}, {31'd0, v.match});
    i2c_stop();
  endtask

  task automatic verifyVector(input vec_t v);
    checkOutput("busy_after_stop", {31'd0, busy}, 0);
    checkOutput("addr_match_after_stop", {31'd0, addr_match}, 0);
    checkOutput("sda_oe_after_stop", {31'd0, sda_oe}, 0);
    checkOutput("err_after_stop", {31'd0, err}, {31'd0, v.err});
    checkOutput("ack_count", ack_cnt - base_ack, v.acks);
    drainScoreboard("vec");
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic ack;
    logic [7:0] d;

    vecs[0] = '{addr: 8'h78, ctrl: 8'h80, nbytes: 1, data: 24'hAF0000, addr_ack: 1'b1, match: 1'b1, acks: 3, dcn: 1'b0, err: 1'b0};
    vecs[1] = '{addr: 8'h78, ctrl: 8'h40, nbytes: 3, data: 24'hFF003C, addr_ack: 1'b1, match: 1'b1, acks: 5, dcn: 1'b1, err: 1'b0};
    vecs[2] = '{addr: 8'h7A, ctrl: 8'h40, nbytes: 1, data: 24'h990000, addr_ack: 1'b0, match: 1'b0, acks: 0, dcn: 1'b1, err: 1'b0};
    vecs[3] = '{addr: 8'h79, ctrl: 8'h80, nbytes: 1, data: 24'h120000, addr_ack: 1'b0, match: 1'b0, acks: 0, dcn: 1'b0, err: 1'b1};
    vecs[4] = '{addr: 8'h78, ctrl: 8'h00, nbytes: 2, data: 24'hAE2000, addr_ack: 1'b1, match: 1'b1, acks: 4, dcn: 1'b0, err: 1'b0};
    vecs[5] = '{addr: 8'h78, ctrl: 8'h81, nbytes: 1, data: 24'h550000, addr_ack: 1'b1, match: 1'b1, acks: 3, dcn: 1'b0, err: 1'b1};

    wait_clks(5);
    checkOutput("rst_sda_oe", {31'd0, sda_oe}, 0);
    checkOutput("rst_busy", {31'd0, busy}, 0);
    checkOutput("rst_addr_match", {31'd0, addr_match}, 0);
    checkOutput("rst_rx_valid", {31'd0, rx_valid}, 0);
    checkOutput("rst_rx_dcn", {31'd0, rx_dcn}, 0);
    checkOutput("rst_rx_data", {24'd0, rx_data}, 0);
    checkOutput("rst_err", {31'd0, err}, 0);
    rst_n = 1'b1;
    wait_clks(10);

    for (int i = 0; i < 6; i++) begin
      $display("[TB] vector %0d: addr %0h ctrl %0h", i, vecs[i].addr, vecs[i].ctrl);
      applyStimulus(vecs[i]);
      verifyVector(vecs[i]);
    end

    // STOP after 4 data bits: partial byte discarded and flagged.
    i2c_start();
    send_byte(8'h78, 1'b0, ack);
    send_byte(8'h80, 1'b0, ack);
    send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
    i2c_stop();
    checkOutput("midbyte_stop_err", {31'd0, err}, 1);
    checkOutput("midbyte_stop_busy", {31'd0, busy}, 0);
    checkOutput("midbyte_stop_sda_oe", {31'd0, sda_oe}, 0);
    drainScoreboard("midbyte");

    // Repeated START inside a data stream drops addr_match and restarts addressing.
    i2c_start();
    send_byte(8'h78, 1'b0, ack);
    send_byte(8'h40, 1'b0, ack);
    exp_q.push_back('{data: 8'h11, dcn: 1'b1});
    send_byte(8'h11, 1'b0, ack);
    i2c_start();
    checkOutput("rstart_addr_match", {31'd0, addr_match}, 0);
    checkOutput("rstart_busy", {31'd0, busy}, 1);
    send_byte(8'h78, 1'b0, ack);
    checkOutput("rstart_addr_ack", {31'd0, ack}, 1);
    send_byte(8'h80, 1'b0, ack);
    exp_q.push_back('{data: 8'h22, dcn: 1'b0});
    send_byte(8'h22, 1'b0, ack);
    i2c_stop();
    checkOutput("rstart_err", {31'd0, err}, 0);
    drainScoreboard("rstart");

    // Asynchronous reset in the middle of a data ACK.
    i2c_start();
    send_byte(8'h78, 1'b0, ack);
    send_byte(8'h40, 1'b0, ack);
    d = 8'h5A;
    exp_q.push_back('{data: d, dcn: 1'b1});
    for (int i = 7; i >= 0; i--) send_bit(d[i], 1'b0);
    sda_drv = 1'b1;
    wait_clks(HALF);
    checkOutput("oe_in_data_ack", {31'd0, sda_oe}, 1);
    drainScoreboard("pre_reset");
    #1 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_sda_oe", {31'd0, sda_oe}, 0);
    checkOutput("async_rst_busy", {31'd0, busy}, 0);
    checkOutput("async_rst_addr_match", {31'd0, addr_match}, 0);
    checkOutput("async_rst_rx_dcn", {31'd0, rx_dcn}, 0);
    checkOutput("async_rst_rx_data", {24'd0, rx_data}, 0);
    checkOutput("async_rst_err", {31'd0, err}, 0);
    wait_clks(3);
    scl = 1'b1;
    wait_clks(5);
    rst_n = 1'b1;
    wait_clks(PH);

    // SCL glitches inside data byte A5.
    i2c_start();
    send_byte(8'h78, 1'b0, ack);
    send_byte(8'h40, 1'b0, ack);
`ifdef I2C_OLED_RX_GLITCH_FILTER_EN
    exp_q.push_back('{data: 8'hA5, dcn: 1'b1});
    send_byte(8'hA5, 1'b1, ack);
    i2c_stop();
    checkOutput("glitch_filtered_data", {24'd0, rx_data}, 32'hA5);
    drainScoreboard("glitch");
`else
    send_byte(8'hA5, 1'b1, ack);
    i2c_stop();
    checkOutput("glitch_unfiltered_corrupts", {31'd0, (rx_data != 8'hA5)}, 1);
    rd_ptr = rx_cnt;
`endif

    checkOutput("rx_valid_single_clk", wide_cnt, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
